// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder: state encoding,
// SRAM strobe idle levels and the strobe decode used by the top level.
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StSetup = 2'b01,
      StWait  = 2'b10,
      StDone  = 2'b11
   } state_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic dq_oe;
   } strobe_t;

   localparam logic CeNIdle  = 1'b1;
   localparam logic OeNIdle  = 1'b1;
   localparam logic WeNIdle  = 1'b1;
   localparam logic DqOeIdle = 1'b0;

   localparam strobe_t StrobeIdle = '{
      ce_n:  CeNIdle,
      oe_n:  OeNIdle,
      we_n:  WeNIdle,
      dq_oe: DqOeIdle
   };

   localparam logic [15:0] OorRdata = 16'h0000;

   // Strobe levels for the cycle spent in state st. Out-of-range accesses walk
   // the same states but never touch the SRAM pins.
   function automatic strobe_t sram_strobes(input state_t st, input logic we,
                                            input logic oor, input logic zero_wait);
      strobe_t s;
      s = StrobeIdle;
      if (!oor) begin
         unique case (st)
            StIdle: s = StrobeIdle;
            StSetup: begin
               s.ce_n = 1'b0;
               if (we) begin
                  s.dq_oe = 1'b1;
                  s.we_n  = !zero_wait;
               end else begin
                  s.oe_n = 1'b0;
               end
            end
            StWait: begin
               s.ce_n = 1'b0;
               if (we) begin
                  s.dq_oe = 1'b1;
                  s.we_n  = 1'b0;
               end else begin
                  s.oe_n = 1'b0;
               end
            end
            StDone: begin
               // CE and DQ drive held one more cycle for write data hold time
               s.ce_n  = 1'b0;
               s.dq_oe = we;
            end
            default: s = StrobeIdle;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// Loadable 4-bit down-counter that times the SRAM wait states; tc is high
// while the count is zero.
module lc3_mem_wait_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       en,
   output logic       tc
);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (en && (count_q != 4'd0)) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == 4'd0);

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 load/store responder driving an asynchronous SRAM with programmable wait
// states. Define LC3_MEM_PIPE_EN to accept the next request during DONE.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [15:0]       req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam logic       ZeroWait = (WAIT_STATES == 0);
   localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   // Address bits above the physical SRAM width; any set bit is out of range.
   localparam logic [15:0] HiMask  = 16'hFFFF << ADDR_W;

   state_t              state_q, state_d;
   strobe_t             strobe_q, strobe_d;
   logic                we_q, we_d;
   logic                oor_q, oor_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         wdata_q;
   logic [15:0]         rdata_q;
   logic                rsp_valid_q;
   logic                accept;
   logic                req_oor;
   logic                capture;
   logic                timer_load;
   logic                timer_en;
   logic                timer_tc;

`ifdef LC3_MEM_PIPE_EN
   assign req_ready = (state_q == StIdle) || (state_q == StDone);
`else
   assign req_ready = (state_q == StIdle);
`endif

   assign accept  = req_valid && req_ready;
   assign req_oor = |(req_addr & HiMask);

   lc3_mem_wait_timer u_wait_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (WaitLoad),
      .en         (timer_en),
      .tc         (timer_tc)
   );

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      capture    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StSetup;
         end
         StSetup: begin
            if (ZeroWait) begin
               state_d = StDone;
               capture = !we_q;
            end else begin
               state_d    = StWait;
               timer_load = 1'b1;
            end
         end
         StWait: begin
            if (timer_tc) begin
               state_d = StDone;
               capture = !we_q;
            end else begin
               timer_en = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
`ifdef LC3_MEM_PIPE_EN
            if (accept) state_d = StSetup;
`endif
         end
         default: state_d = StIdle;
      endcase

      // Strobes are registered, so decode them from the state being entered.
      we_d     = accept ? req_we  : we_q;
      oor_d    = accept ? req_oor : oor_q;
      strobe_d = sram_strobes(state_d, we_d, oor_d, ZeroWait);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         strobe_q    <= StrobeIdle;
         we_q        <= 1'b0;
         oor_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         rdata_q     <= 16'h0000;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         strobe_q    <= strobe_d;
         we_q        <= we_d;
         oor_q       <= oor_d;
         rsp_valid_q <= (state_d == StDone);
         if (accept) begin
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
         end
         if (capture) begin
            rdata_q <= oor_q ? OorRdata : sram_dq_in;
         end
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = wdata_q;
   assign sram_dq_oe  = strobe_q.dq_oe;
   assign sram_ce_n   = strobe_q.ce_n;
   assign sram_oe_n   = strobe_q.oe_n;
   assign sram_we_n   = strobe_q.we_n;

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC3 core's load/store path.
- The core's control unit issues load requests (from MAR) and store requests (from MAR + MEM_WE). This block accepts each request, runs a multi-cycle cycle on the external asynchronous SRAM with programmable wait states, and returns read data or a write acknowledge.
- Sits between the datapath's MAR/MDR and the board SRAM pins.

Parameters:
- WAIT_STATES, 2, number of SRAM wait cycles per access (0..15).
- ADDR_W, 16, physical SRAM address width (1..16).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  core presents a request.
- REQ_READY  out  1  responder can accept a request this cycle.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  16  word address (MAR).
- REQ_WDATA  in  16  store data (MDR).
- RSP_VALID  out  1  one-cycle pulse: access complete.
- RSP_RDATA  out  16  load data; holds until the next load completes.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_DQ_OUT  out  16  SRAM write data.
- SRAM_DQ_OE  out  1  drive enable for the data bus.
- SRAM_DQ_IN  in  16  SRAM read data.
- SRAM_CE_N  out  1  chip enable, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_WE_N  out  1  write enable, active-low.

Behaviour:
- Reset values (applied asynchronously): state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=16'h0000, SRAM_CE_N/OE_N/WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0.
- Handshake: a request is accepted on a rising edge with REQ_VALID && REQ_READY. ADDR, WDATA and WE are latched at that edge; the core may change its inputs afterwards.
- REQ_READY=1 only in IDLE. REQ_VALID while not ready is ignored, not queued.
- State machine:
  - IDLE: accept -> SETUP.
  - SETUP (1 cycle): CE_N=0 and SRAM_ADDR valid. Read: OE_N=0. Write: DQ_OE=1. -> WAIT if WAIT_STATES>0, else -> DONE.
  - WAIT (WAIT_STATES cycles, down-counter): read keeps OE_N=0; write asserts WE_N=0. On the last WAIT cycle a read captures SRAM_DQ_IN into RSP_RDATA. -> DONE.
  - DONE (1 cycle): RSP_VALID=1 and WE_N=1. CE_N and DQ_OE stay asserted to give write data hold time. -> IDLE.
- WAIT_STATES=0:
  - A read captures data at the end of SETUP.
  - A write asserts WE_N=0 during SETUP.
- Latency: RSP_VALID is high WAIT_STATES+2 cycles after the accepting edge. Throughput is one access per WAIT_STATES+3 cycles.
- Out of range: if ADDR_W<16 and any REQ_ADDR[15:ADDR_W] bit is 1:
  - no SRAM strobes are driven;
  - the same state sequence runs;
  - a read returns 16'h0000;
  - a write is dropped but still acknowledged.
- RSP_RDATA is unchanged by writes.
- Reset mid-access: all strobes deassert immediately and the in-flight request is lost with no RSP_VALID. The core re-issues the request after reset.

Optional Feature:
- Macro: LC3_MEM_PIPE_EN.
- Defined:
  - REQ_READY is also 1 in DONE.
  - A request accepted in DONE goes straight to SETUP, skipping IDLE.
  - CE_N stays low across the boundary; OE_N, WE_N and DQ_OE take the new request's values from SETUP on.
  - Throughput becomes one access per WAIT_STATES+2 cycles.
- Undefined: behaviour exactly as above.

Decomposition:
- Package lc3_mem_pkg:
  - state encoding (IDLE=2'b00, SETUP=2'b01, WAIT=2'b10, DONE=2'b11);
  - SRAM strobe idle-level constants;
  - out-of-range read value 16'h0000.
- One sub-module, lc3_mem_wait_timer:
  - loadable 4-bit down-counter;
  - load input and terminal-count output;
  - asynchronous active-low reset.

Test Plan:
- Reset then idle: after RESET_N deasserts → REQ_READY=1, all SRAM strobes high, RSP_RDATA=16'h0000.
- Write then read, WAIT_STATES=2:
  - store 16'hBEEF to x3000 → WE_N low for exactly 2 cycles with SRAM_ADDR=x3000, RSP_VALID 4 cycles after accept.
  - load from x3000 → RSP_RDATA=16'hBEEF with RSP_VALID.
- Back-pressure: hold REQ_VALID through a busy access → exactly two accepts, no third spurious access, RSP_VALID pulses exactly twice.
- Out of range, ADDR_W=12:
  - load from x8000 → RSP_RDATA=16'h0000, CE_N never low;
  - store to x8000 → ack with no WE_N pulse.
- Reset mid-access: assert RESET_N low during WAIT → strobes high the same cycle, no RSP_VALID, next load of x3000 works normally.
- LC3_MEM_PIPE_EN, WAIT_STATES=0: back-to-back loads from x0010 and x0011 → RSP_VALID pulses 2 cycles apart, CE_N continuously low.
